// File: rtl/prog_pkg.sv
// rtl/prog_pkg.sv - shared types and sizing for the program-memory loader
package prog_pkg;

  localparam int PSIZE_DEF = 6;
  localparam int ISIZE_DEF = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } loader_state_t;

  function automatic int bytes_per_instr(input int isize);
    return (isize + 7) / 8;
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - shifts stream bytes MS-first into one instruction word
// word is the value the shifter holds once the byte on din has been taken in.
module byte_assembler
  import prog_pkg::*;
#(
  parameter int Isize = ISIZE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [7:0]       din,
  output logic [Isize-1:0] word,
  output logic             last_byte
);

  localparam int BYTES = bytes_per_instr(Isize);
  localparam int SW    = BYTES * 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [SW-1:0] sr;
  logic [SW-1:0] sr_next;
  logic [CW-1:0] cnt;

  // Surplus top bits of the first byte fall off the truncation to Isize.
  assign sr_next   = (sr << 8) | SW'(din);
  assign word      = sr_next[Isize-1:0];
  assign last_byte = (cnt == CW'(BYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= sr_next;
      cnt <= last_byte ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte stream to program memory writer with CPU hold
module prog_loader
  import prog_pkg::*;
#(
  parameter int Psize = PSIZE_DEF,
  parameter int Isize = ISIZE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             pm_we,
  output logic [Psize-1:0] pm_addr,
  output logic [Isize-1:0] pm_wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cpu_hold
);

  localparam logic [31:0] DEPTH = 32'd1 << Psize;

  loader_state_t state, next_state;

  logic [Psize-1:0] index;
  logic [Psize-1:0] last_index;
  logic [7:0]       chk_xor;
  logic             accept;
  logic             start_load;
  logic             len_bad;
  logic             last_byte;
  logic [Isize-1:0] word;

  assign accept     = rx_valid && rx_ready;
  assign start_load = start && (state == IDLE || state == DONE || state == ERR);
  assign len_bad    = {24'd0, rx_data} > DEPTH;
  assign cpu_hold   = busy;

  byte_assembler #(.Isize(Isize)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_load),
    .shift_en  (accept && state == DATA),
    .din       (rx_data),
    .word      (word),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = LEN;
      LEN:             if (accept) next_state = len_bad ? ERR : DATA;
      DATA:            if (accept && last_byte) next_state = WRITE;
      WRITE:           next_state = (index == last_index) ? CHK : DATA;
      CHK:             if (accept) next_state = (rx_data == chk_xor) ? DONE : ERR;
      default:         next_state = IDLE;
    endcase
  end

  // Status and strobe outputs are registered from next_state so they align with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_wdata   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      index      <= '0;
      last_index <= '0;
      chk_xor    <= 8'd0;
    end else begin
      rx_ready <= (next_state == LEN) || (next_state == DATA) || (next_state == CHK);
      busy     <= !(next_state == IDLE || next_state == DONE || next_state == ERR);
      pm_we    <= (next_state == WRITE);

      if (start_load) begin
        done    <= 1'b0;
        err     <= 1'b0;
        index   <= '0;
        chk_xor <= 8'd0;
      end else if (accept && state != CHK) begin
        chk_xor <= chk_xor ^ rx_data;
      end

      if (state == LEN && accept) begin
        last_index <= (rx_data == 8'd0) ? '1 : Psize'(rx_data - 8'd1);
        if (len_bad) err <= 1'b1;
      end

      if (state == DATA && accept && last_byte) begin
        pm_addr  <= index;
        pm_wdata <= word;
      end

      if (state == WRITE && index != last_index) index <= index + Psize'(1);

      if (state == CHK && accept) begin
        if (rx_data == chk_xor) done <= 1'b1;
        else                    err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized frame bench for prog_loader with a queue-based model
module tb_prog_loader;

  localparam int PS    = 6;
  localparam int IS    = 24;
  localparam int NB    = (IS + 7) / 8;
  localparam int DEPTH = 1 << PS;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          pm_we;
  logic [PS-1:0] pm_addr;
  logic [IS-1:0] pm_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_hold;

  prog_loader #(.Psize(PS), .Isize(IS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .pm_we    (pm_we),
    .pm_addr  (pm_addr),
    .pm_wdata (pm_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  frame[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done;
  bit          exp_err;
  bit          chk_en = 1'b0;
  int          we_cnt;
  logic [31:0] last_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("cpu_hold_eq_busy", 32'(cpu_hold), 32'(busy));
      if (!busy) check("ready_low_when_idle", 32'(rx_ready), 32'd0);
      if (pm_we) begin
        we_cnt++;
        last_addr = 32'(pm_addr);
        check("ready_low_in_write", 32'(rx_ready), 32'd0);
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", pm_addr, pm_wdata);
        end else begin
          check("pm_addr", 32'(pm_addr), exp_addr.pop_front());
          check("pm_wdata", 32'(pm_wdata), exp_data.pop_front());
        end
      end
    end
  end

  // Model: frame = LEN, each word MS byte first, XOR checksum; writes are word i at address i.
  task automatic build_frame(input int n, input bit use_zero, input bit bad_chk);
    logic [7:0]    len;
    logic [7:0]    x;
    logic [IS-1:0] w;
    frame.delete();
    len = (use_zero && n == DEPTH) ? 8'd0 : 8'(n);
    frame.push_back(len);
    x = len;
    for (int i = 0; i < n; i++) begin
      w = IS'($urandom);
      exp_addr.push_back(32'(i));
      exp_data.push_back(32'(w));
      for (int b = NB - 1; b >= 0; b--) begin
        frame.push_back(8'(w >> (8 * b)));
        x = x ^ 8'(w >> (8 * b));
      end
    end
    if (bad_chk) x = x ^ 8'($urandom_range(1, 255));
    frame.push_back(x);
    exp_done = !bad_chk;
    exp_err  = bad_chk;
  endtask

  task automatic frame1(input logic [7:0] chk);
    frame.delete();
    frame = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, chk};
    exp_addr.push_back(32'd0); exp_data.push_back(32'h123456);
    exp_addr.push_back(32'd1); exp_data.push_back(32'hABCDEF);
    exp_done = (chk == 8'hFB);
    exp_err  = (chk != 8'hFB);
  endtask

  // Start is pulsed together with a valid LEN byte, which must not be taken in IDLE.
  task automatic send(input int count, input bit gaps);
    int budget;
    bit ok;
    @(negedge clk);
    start = 1'b1; rx_valid = 1'b1; rx_data = frame[0];
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < count; k++) begin
      ok = 1'b0;
      budget = 0;
      while (!ok && budget < 40) begin
        if (budget > 0) @(negedge clk);
        budget++;
        if (gaps && $urandom_range(0, 2) == 0) begin
          rx_valid = 1'b0;
        end else begin
          rx_valid = 1'b1;
          rx_data  = frame[k];
          if (rx_ready) begin
            @(posedge clk);
            ok = 1'b1;
          end
        end
      end
      if (!ok) check("byte_accept_timeout", 32'(k), 32'(count));
      if (!ok) break;
      if (k + 1 < count) @(negedge clk);
    end
    #1 rx_valid = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int n_writes);
    int t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_err"}, 32'(err), 32'(exp_err));
    check({name, "_we_count"}, 32'(we_cnt), 32'(n_writes));
    check({name, "_writes_left"}, 32'(exp_addr.size()), 32'd0);
    exp_addr.delete();
    exp_data.delete();
    we_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; we_cnt = 0; last_addr = 0;
    #12;
    check("reset_rx_ready", 32'(rx_ready), 32'd0);
    check("reset_pm_we", 32'(pm_we), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done_err", {30'd0, done, err}, 32'd0);
    check("reset_cpu_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    frame1(8'hFB);
    send(frame.size(), 1'b0);
    finish_frame("t1_good", 2);

    frame1(8'h00);
    send(frame.size(), 1'b0);
    finish_frame("t2_badchk", 2);

    build_frame(DEPTH, 1'b1, 1'b0);
    send(frame.size(), 1'b0);
    check("t3_len_byte_zero", 32'(frame[0]), 32'd0);
    finish_frame("t3_full", DEPTH);
    check("t3_last_addr", last_addr, 32'd63);

    frame.delete();
    frame.push_back(8'h41);
    exp_done = 1'b0; exp_err = 1'b1;
    send(1, 1'b0);
    @(negedge clk);
    check("t4_err_next_cycle", 32'(err), 32'd1);
    check("t4_rx_ready", 32'(rx_ready), 32'd0);
    finish_frame("t4_badlen", 0);

    frame1(8'hFB);
    send(frame.size(), 1'b1);
    finish_frame("t5_gaps", 2);

    for (int r = 0; r < 8; r++) begin
      int n;
      bit bad;
      n   = $urandom_range(1, DEPTH);
      bad = ($urandom_range(0, 3) == 0);
      build_frame(n, $urandom_range(0, 1) == 1, bad);
      send(frame.size(), $urandom_range(0, 1) == 1);
      finish_frame("rand", n);
    end

    frame.delete();
    frame.push_back(8'hF0);
    exp_done = 1'b0; exp_err = 1'b1;
    send(1, 1'b0);
    finish_frame("badlen_f0", 0);

    chk_en = 1'b0;
    frame1(8'hFB);
    send(4, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("t6_async_pm_we", 32'(pm_we), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_rx_ready", 32'(rx_ready), 32'd0);
    check("t6_async_hold", 32'(cpu_hold), 32'd0);
    check("t6_async_addr_data", 32'(pm_addr) | 32'(pm_wdata), 32'd0);
    check("t6_async_flags", {30'd0, done, err}, 32'd0);
    exp_addr.delete();
    exp_data.delete();
    we_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    frame1(8'hFB);
    send(frame.size(), 1'b0);
    finish_frame("t6_reload", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
